// File: rtl/gpr_writeback_arbiter.sv
// GPR write-port arbiter: ALU has fixed priority, LSU/MDU share round-robin,
// one registered write per cycle, plus a pending-write scoreboard for RAW stalls.
module gpr_writeback_arbiter #(
    parameter int WIDTH     = 64,
    parameter int REG_WIDTH = 5,
    parameter int REG_NUM   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alu_valid_i,
    input  logic [REG_WIDTH-1:0] alu_rd_i,
    input  logic [WIDTH-1:0]     alu_data_i,
    output logic                 alu_ready_o,
    input  logic                 lsu_valid_i,
    input  logic [REG_WIDTH-1:0] lsu_rd_i,
    input  logic [WIDTH-1:0]     lsu_data_i,
    output logic                 lsu_ready_o,
    input  logic                 mdu_valid_i,
    input  logic [REG_WIDTH-1:0] mdu_rd_i,
    input  logic [WIDTH-1:0]     mdu_data_i,
    output logic                 mdu_ready_o,
    input  logic                 issue_valid_i,
    input  logic [REG_WIDTH-1:0] issue_rd_i,
    output logic [REG_WIDTH-1:0] rd_waddr_o,
    output logic [WIDTH-1:0]     rd_wdata_o,
    output logic                 wen_o,
    output logic [REG_NUM-1:0]   busy_o
);

    // ptr_q = 0 favours LSU on a contested grant, 1 favours MDU
    logic                 ptr_q, ptr_d;
    logic [REG_WIDTH-1:0] waddr_q, waddr_d;
    logic [WIDTH-1:0]     wdata_q, wdata_d;
    logic                 wen_q, wen_d;
    logic [REG_NUM-1:0]   busy_q, busy_d;

    logic                 alu_gnt, lsu_gnt, mdu_gnt, contested;
    logic [REG_WIDTH-1:0] sel_rd;
    logic [WIDTH-1:0]     sel_data;

    always_comb begin
        alu_gnt   = 1'b0;
        lsu_gnt   = 1'b0;
        mdu_gnt   = 1'b0;
        contested = 1'b0;
        if (!rst) begin
            if (alu_valid_i) begin
                alu_gnt = 1'b1;
            end else if (lsu_valid_i && mdu_valid_i) begin
                contested = 1'b1;
                lsu_gnt   = !ptr_q;
                mdu_gnt   = ptr_q;
            end else begin
                lsu_gnt = lsu_valid_i;
                mdu_gnt = mdu_valid_i;
            end
        end
    end

    assign alu_ready_o = alu_gnt;
    assign lsu_ready_o = lsu_gnt;
    assign mdu_ready_o = mdu_gnt;

    always_comb begin
        sel_rd   = mdu_rd_i;
        sel_data = mdu_data_i;
        if (alu_gnt) begin
            sel_rd   = alu_rd_i;
            sel_data = alu_data_i;
        end else if (lsu_gnt) begin
            sel_rd   = lsu_rd_i;
            sel_data = lsu_data_i;
        end
    end

    always_comb begin
        ptr_d   = contested ? !ptr_q : ptr_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        wen_d   = 1'b0;
        if (alu_gnt || lsu_gnt || mdu_gnt) begin
            waddr_d = sel_rd;
            wdata_d = sel_data;
            wen_d   = (sel_rd != '0);
        end
    end

    // Clear first, then set, so a new writer to the same register keeps it busy
    always_comb begin
        busy_d = busy_q;
        if (wen_q) begin
            busy_d[waddr_q] = 1'b0;
        end
        if (issue_valid_i && (issue_rd_i != '0)) begin
            busy_d[issue_rd_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            wen_q   <= 1'b0;
            busy_q  <= '0;
        end else begin
            ptr_q   <= ptr_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            wen_q   <= wen_d;
            busy_q  <= busy_d;
        end
    end

    assign rd_waddr_o = waddr_q;
    assign rd_wdata_o = wdata_q;
    assign wen_o      = wen_q;
    assign busy_o     = busy_q;

endmodule

// File: tb/tb_gpr_writeback_arbiter.sv
// Directed self-checking bench for gpr_writeback_arbiter.
module tb_gpr_writeback_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid_i, lsu_valid_i, mdu_valid_i, issue_valid_i;
    logic [4:0]  alu_rd_i, lsu_rd_i, mdu_rd_i, issue_rd_i;
    logic [63:0] alu_data_i, lsu_data_i, mdu_data_i;
    logic        alu_ready_o, lsu_ready_o, mdu_ready_o;
    logic [4:0]  rd_waddr_o;
    logic [63:0] rd_wdata_o;
    logic        wen_o;
    logic [31:0] busy_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    gpr_writeback_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .alu_valid_i  (alu_valid_i),
        .alu_rd_i     (alu_rd_i),
        .alu_data_i   (alu_data_i),
        .alu_ready_o  (alu_ready_o),
        .lsu_valid_i  (lsu_valid_i),
        .lsu_rd_i     (lsu_rd_i),
        .lsu_data_i   (lsu_data_i),
        .lsu_ready_o  (lsu_ready_o),
        .mdu_valid_i  (mdu_valid_i),
        .mdu_rd_i     (mdu_rd_i),
        .mdu_data_i   (mdu_data_i),
        .mdu_ready_o  (mdu_ready_o),
        .issue_valid_i(issue_valid_i),
        .issue_rd_i   (issue_rd_i),
        .rd_waddr_o   (rd_waddr_o),
        .rd_wdata_o   (rd_wdata_o),
        .wen_o        (wen_o),
        .busy_o       (busy_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge and settle 1 time unit after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_rdy(input string tag, input logic a, input logic l, input logic m);
        #1;
        chk({tag, "_alu_rdy"}, {63'd0, alu_ready_o}, {63'd0, a});
        chk({tag, "_lsu_rdy"}, {63'd0, lsu_ready_o}, {63'd0, l});
        chk({tag, "_mdu_rdy"}, {63'd0, mdu_ready_o}, {63'd0, m});
    endtask

    task automatic chk_wr(input string tag, input logic w, input logic [4:0] a, input logic [63:0] d);
        chk({tag, "_wen"},   {63'd0, wen_o},      {63'd0, w});
        chk({tag, "_waddr"}, {59'd0, rd_waddr_o}, {59'd0, a});
        chk({tag, "_wdata"}, rd_wdata_o,          d);
    endtask

    task automatic idle_inputs();
        alu_valid_i = 0; lsu_valid_i = 0; mdu_valid_i = 0; issue_valid_i = 0;
    endtask

    initial begin
        // Reset with every input active
        rst = 1;
        alu_valid_i = 1; alu_rd_i = 5'd4; alu_data_i = 64'hA;
        lsu_valid_i = 1; lsu_rd_i = 5'd6; lsu_data_i = 64'hB;
        mdu_valid_i = 1; mdu_rd_i = 5'd8; mdu_data_i = 64'hC;
        issue_valid_i = 1; issue_rd_i = 5'd9;
        chk_rdy("rst0", 0, 0, 0);
        tick();
        chk_rdy("rst1", 0, 0, 0);
        tick();
        rst = 0;
        idle_inputs();
        chk_wr("rst_out", 0, 5'd0, 64'd0);
        chk("rst_busy", {32'd0, busy_o}, 64'd0);
        tick();
        chk("idle_wen", {63'd0, wen_o}, 64'd0);

        // Single ALU write, then hold
        alu_valid_i = 1; alu_rd_i = 5'd5; alu_data_i = 64'hDEAD_BEEF;
        chk_rdy("alu", 1, 0, 0);
        tick();
        idle_inputs();
        chk_wr("alu_w", 1, 5'd5, 64'hDEAD_BEEF);
        tick();
        chk_wr("alu_hold", 0, 5'd5, 64'hDEAD_BEEF);

        // Three-way contention, each source drops after acceptance
        alu_valid_i = 1; alu_rd_i = 5'd1; alu_data_i = 64'h11;
        lsu_valid_i = 1; lsu_rd_i = 5'd2; lsu_data_i = 64'h22;
        mdu_valid_i = 1; mdu_rd_i = 5'd3; mdu_data_i = 64'h33;
        chk_rdy("c3a", 1, 0, 0);
        tick();
        alu_valid_i = 0;
        chk_wr("c3a_w", 1, 5'd1, 64'h11);
        chk_rdy("c3b", 0, 1, 0);
        tick();
        lsu_valid_i = 0;
        chk_wr("c3b_w", 1, 5'd2, 64'h22);
        chk_rdy("c3c", 0, 0, 1);
        tick();
        mdu_valid_i = 0;
        chk_wr("c3c_w", 1, 5'd3, 64'h33);

        // LSU/MDU only: pointer now favours MDU, then alternates
        lsu_valid_i = 1; lsu_rd_i = 5'd10; lsu_data_i = 64'hA0;
        mdu_valid_i = 1; mdu_rd_i = 5'd11; mdu_data_i = 64'hB0;
        chk_rdy("rr1", 0, 0, 1);
        tick();
        chk_wr("rr1_w", 1, 5'd11, 64'hB0);
        chk_rdy("rr2", 0, 1, 0);
        tick();
        chk_wr("rr2_w", 1, 5'd10, 64'hA0);
        chk_rdy("rr3", 0, 0, 1);
        tick();
        idle_inputs();
        chk_wr("rr3_w", 1, 5'd11, 64'hB0);

        // x0 write from MDU
        mdu_valid_i = 1; mdu_rd_i = 5'd0; mdu_data_i = 64'h1234;
        chk_rdy("x0", 0, 0, 1);
        tick();
        idle_inputs();
        chk_wr("x0_w", 0, 5'd0, 64'h1234);
        chk("x0_busy", {32'd0, busy_o}, 64'd0);

        // Scoreboard: set, same-register set/clear collision, independent set/clear
        issue_valid_i = 1; issue_rd_i = 5'd7;
        tick();
        issue_valid_i = 0;
        chk("sb_set7", {32'd0, busy_o}, 64'h80);
        lsu_valid_i = 1; lsu_rd_i = 5'd7; lsu_data_i = 64'h77;
        tick();
        lsu_valid_i = 0;
        issue_valid_i = 1; issue_rd_i = 5'd7;
        chk_wr("sb_w7a", 1, 5'd7, 64'h77);
        tick();
        issue_valid_i = 0;
        chk("sb_setwins", {32'd0, busy_o}, 64'h80);
        lsu_valid_i = 1; lsu_rd_i = 5'd7; lsu_data_i = 64'h78;
        tick();
        lsu_valid_i = 0;
        issue_valid_i = 1; issue_rd_i = 5'd9;
        chk_wr("sb_w7b", 1, 5'd7, 64'h78);
        tick();
        issue_valid_i = 0;
        chk("sb_indep", {32'd0, busy_o}, 64'h200);
        issue_valid_i = 1; issue_rd_i = 5'd0;
        tick();
        idle_inputs();
        chk("sb_x0_issue", {32'd0, busy_o}, 64'h200);

        // Reset mid-flight: accepted LSU write is discarded
        lsu_valid_i = 1; lsu_rd_i = 5'd12; lsu_data_i = 64'h55;
        issue_valid_i = 1; issue_rd_i = 5'd12;
        chk_rdy("mf_acc", 0, 1, 0);
        tick();
        idle_inputs();
        rst = 1;
        lsu_valid_i = 1; mdu_valid_i = 1;
        chk_rdy("mf_rst", 0, 0, 0);
        tick();
        rst = 0;
        idle_inputs();
        chk_wr("mf_out", 0, 5'd0, 64'd0);
        chk("mf_busy", {32'd0, busy_o}, 64'd0);

        // Pointer back to LSU after reset
        lsu_valid_i = 1; lsu_rd_i = 5'd13; lsu_data_i = 64'hC3;
        mdu_valid_i = 1; mdu_rd_i = 5'd14; mdu_data_i = 64'hC4;
        chk_rdy("ptr_rst", 0, 1, 0);
        tick();
        idle_inputs();
        chk_wr("ptr_rst_w", 1, 5'd13, 64'hC3);
        tick();
        chk("final_idle", {63'd0, wen_o}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
